// File: rtl/img_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// img_xfer_ctrl
//
// Frame-level transfer scheduler for the camera-to-UDP image path. Runs in the
// cam_pclk domain. At the start of each vertical blank it decides whether the
// next frame goes out. The decision depends on the host request and on frame
// decimation. The module also gates the pixel enable into the packetizer,
// aborts a frame when the packetizer FIFO overflows, and checks the size of
// every sent frame against the configured resolution.
//
// Parameters
//   H_PIXEL        valid pixels (img_data_en beats) per line
//   V_PIXEL        lines per frame
//
// Ports
//   cam_pclk       in   pixel clock
//   rst_n          in   asynchronous, active-low reset
//   img_vsync      in   high = vertical blank; falling edge starts a frame,
//                       rising edge ends it
//   img_data_en    in   pixel valid
//   xfer_req       in   host start/stop level (eth_tx_clk domain, synchronised here)
//   skip_n         in   decimation: one frame sent out of every skip_n+1
//   fifo_full      in   packetizer FIFO full
//   transfer_flag  out  registered; 1 = packetizer enabled (0 holds its FIFO in reset)
//   pix_en         out  gated pixel enable (combinational)
//   frame_done     out  1-cycle pulse at the end of every completed sent frame
//   frame_err      out  1-cycle pulse with frame_done when the frame size is wrong
//   frame_cnt      out  completed sent frames, wrapping
//   drop_cnt       out  frames aborted by FIFO overflow, saturating
// -----------------------------------------------------------------------------
module img_xfer_ctrl #(
    parameter logic [15:0] H_PIXEL = 16'd640,
    parameter logic [15:0] V_PIXEL = 16'd480
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        img_vsync,
    input  logic        img_data_en,
    input  logic        xfer_req,
    input  logic [3:0]  skip_n,
    input  logic        fifo_full,
    output logic        transfer_flag,
    output logic        pix_en,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACTIVE,
        SKIP,
        DROP
    } state_t;

    state_t      state;
    logic        v_d0;
    logic        v_d1;
    logic        req_m;
    logic        req_s;
    logic [3:0]  skip_cnt;
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;

    logic        vs_rise;
    logic        vs_fall;
    logic        dec_send;
    state_t      dec_state;
    logic [3:0]  dec_skip_cnt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign vs_rise = v_d0 & ~v_d1;
    assign vs_fall = ~v_d0 & v_d1;

    assign pix_en = img_data_en & (state == ACTIVE) & ~fifo_full;

    // Frame decision taken at the start of every blank. The ">=" compare
    // also covers skip_n being lowered below the running skip count: in
    // that case the next frame is sent rather than waiting for a wrap.
    always_comb begin
        dec_send     = 1'b0;
        dec_state    = IDLE;
        dec_skip_cnt = skip_cnt;
        if (req_s) begin
            if (skip_cnt >= skip_n) begin
                dec_send     = 1'b1;
                dec_state    = ARM;
                dec_skip_cnt = 4'd0;
            end else begin
                dec_state    = SKIP;
                dec_skip_cnt = skip_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            v_d0          <= 1'b0;
            v_d1          <= 1'b0;
            req_m         <= 1'b0;
            req_s         <= 1'b0;
            skip_cnt      <= 4'd0;
            pix_cnt       <= 16'd0;
            line_cnt      <= 16'd0;
            transfer_flag <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            frame_cnt     <= 16'd0;
            drop_cnt      <= 8'd0;
        end else begin
            v_d0       <= img_vsync;
            v_d1       <= v_d0;
            req_m      <= xfer_req;
            req_s      <= req_m;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE, SKIP, DROP: begin
                    if (vs_rise) begin
                        state         <= dec_state;
                        transfer_flag <= dec_send;
                        skip_cnt      <= dec_skip_cnt;
                    end
                end

                // Armed during blank. A withdrawn request cancels the frame
                // before it starts, so the packetizer is never enabled.
                ARM: begin
                    if (!req_s) begin
                        state         <= IDLE;
                        transfer_flag <= 1'b0;
                    end else if (vs_fall) begin
                        state    <= ACTIVE;
                        pix_cnt  <= 16'd0;
                        line_cnt <= 16'd0;
                    end
                end

                // Frame end takes priority over an overflow in the same cycle.
                // An overflow in that cycle is counted as a normal frame end.
                ACTIVE: begin
                    if (vs_rise) begin
                        frame_done    <= 1'b1;
                        frame_err     <= !((line_cnt == V_PIXEL) && (pix_cnt == 16'd0));
                        frame_cnt     <= frame_cnt + 16'd1;
                        state         <= dec_state;
                        transfer_flag <= dec_send;
                        skip_cnt      <= dec_skip_cnt;
                    end else if (img_data_en && fifo_full) begin
                        state         <= DROP;
                        transfer_flag <= 1'b0;
                        drop_cnt      <= sat_inc8(drop_cnt);
                    end else if (img_data_en) begin
                        if (pix_cnt == H_PIXEL - 16'd1) begin
                            pix_cnt  <= 16'd0;
                            line_cnt <= sat_inc16(line_cnt);
                        end else begin
                            pix_cnt <= pix_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    transfer_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_xfer_ctrl.sv
module tb_img_xfer_ctrl;

    localparam int H = 8;
    localparam int V = 4;

    logic        cam_pclk = 1'b0;
    logic        rst_n;
    logic        img_vsync;
    logic        img_data_en;
    logic        xfer_req;
    logic [3:0]  skip_n;
    logic        fifo_full;
    logic        transfer_flag;
    logic        pix_en;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;

    img_xfer_ctrl #(
        .H_PIXEL(16'(H)),
        .V_PIXEL(16'(V))
    ) dut (
        .cam_pclk     (cam_pclk),
        .rst_n        (rst_n),
        .img_vsync    (img_vsync),
        .img_data_en  (img_data_en),
        .xfer_req     (xfer_req),
        .skip_n       (skip_n),
        .fifo_full    (fifo_full),
        .transfer_flag(transfer_flag),
        .pix_en       (pix_en),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 cam_pclk = ~cam_pclk;

    // Free-running event counters sampled on the inactive edge.
    int n_pix  = 0;
    int n_done = 0;
    int n_err  = 0;
    always @(negedge cam_pclk) begin
        if (pix_en === 1'b1)     n_pix  <= n_pix + 1;
        if (frame_done === 1'b1) n_done <= n_done + 1;
        if (frame_err === 1'b1)  n_err  <= n_err + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    // One frame as seen by the stimulus: the host request and decimation set
    // during it, the number of pixel beats, the beat index that hits a full
    // FIFO (-1: none), and whether the request is withdrawn during the
    // following blank. The e_* fields hold hand-derived expectations for
    // directed frames.
    typedef struct {
        bit         req;
        logic [3:0] skn;
        int         beats;
        int         ovf;
        bit         arm_drop;
        bit         e_sent;
        int         e_pix;
        int         e_done;
        int         e_err;
    } frame_t;

    function automatic frame_t mk(bit req, int skn, int beats, int ovf, bit arm_drop,
                                  bit e_sent, int e_pix, int e_done, int e_err);
        frame_t f;
        f.req = req; f.skn = 4'(skn); f.beats = beats; f.ovf = ovf; f.arm_drop = arm_drop;
        f.e_sent = e_sent; f.e_pix = e_pix; f.e_done = e_done; f.e_err = e_err;
        return f;
    endfunction

    // Frame-level reference model: which frame goes out, and running counters.
    bit m_next = 1'b0;
    int m_skip = 0;
    int m_fcnt = 0;
    int m_dcnt = 0;

    task automatic model_reset();
        m_next = 1'b0;
        m_skip = 0;
        m_fcnt = 0;
        m_dcnt = 0;
    endtask

    // Out of every skip_n+1 requested frames one is sent; the count of frames
    // passed over since the last send decides.
    task automatic model_decide();
        if (!xfer_req) begin
            m_next = 1'b0;
        end else if (m_skip >= int'(skip_n)) begin
            m_next = 1'b1;
            m_skip = 0;
        end else begin
            m_next = 1'b0;
            m_skip = m_skip + 1;
        end
    endtask

    task automatic do_frame(input frame_t f, input bit use_tbl);
        bit m_sent;
        int m_pix, m_done, m_err;
        bit x_sent;
        int x_pix, x_done, x_err;
        int p0, d0, r0;

        m_sent = m_next;
        m_pix = 0; m_done = 0; m_err = 0;
        if (m_sent) begin
            if (f.ovf >= 0 && f.ovf < f.beats) begin
                m_pix = f.ovf;
            end else begin
                m_pix  = f.beats;
                m_done = 1;
                m_err  = (f.beats != H * V) ? 1 : 0;
            end
        end
        if (use_tbl) begin
            x_sent = f.e_sent; x_pix = f.e_pix; x_done = f.e_done; x_err = f.e_err;
        end else begin
            x_sent = m_sent; x_pix = m_pix; x_done = m_done; x_err = m_err;
        end

        repeat (4) tick();
        p0 = n_pix; d0 = n_done; r0 = n_err;
        img_vsync = 1'b0;
        repeat (3) tick();
        xfer_req = f.req;
        skip_n   = f.skn;
        check("flag_in_frame", 32'(transfer_flag), 32'(x_sent));

        for (int b = 0; b < f.beats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                img_data_en = 1'b0;
                fifo_full   = 1'($urandom_range(0, 1));
                tick();
            end
            img_data_en = 1'b1;
            fifo_full   = (b == f.ovf);
            tick();
            if (b == f.ovf && x_sent)
                check("flag_after_ovf", 32'(transfer_flag), 32'd0);
        end
        img_data_en = 1'b0;
        fifo_full   = 1'b0;
        repeat (2) tick();
        img_vsync = 1'b1;
        repeat (5) tick();

        check("pix_en_beats", n_pix - p0, x_pix);
        check("frame_done_cnt", n_done - d0, x_done);
        check("frame_err_cnt", n_err - r0, x_err);

        if (m_sent && m_pix < f.beats) begin
            if (m_dcnt < 255) m_dcnt++;
        end
        m_fcnt = (m_fcnt + m_done) & 16'hFFFF;
        check("frame_cnt", 32'(frame_cnt), m_fcnt);
        check("drop_cnt", 32'(drop_cnt), m_dcnt);

        model_decide();
        if (f.arm_drop) begin
            xfer_req = 1'b0;
            repeat (3) tick();
            check("flag_req_drop_blank", 32'(transfer_flag), 32'd0);
            m_next = 1'b0;
        end
    endtask

    frame_t tbl[19];

    initial begin
        int p0;
        frame_t f;

        // req skn beats ovf arm | sent pix done err
        tbl[0]  = mk(1, 0, 32, -1, 0, 0,  0, 0, 0);
        tbl[1]  = mk(1, 0, 32, -1, 0, 1, 32, 1, 0);
        tbl[2]  = mk(1, 0, 32, -1, 0, 1, 32, 1, 0);
        tbl[3]  = mk(1, 2, 32, -1, 0, 1, 32, 1, 0);
        tbl[4]  = mk(1, 2, 32, -1, 0, 0,  0, 0, 0);
        tbl[5]  = mk(1, 2, 32, -1, 0, 0,  0, 0, 0);
        tbl[6]  = mk(1, 2, 32, -1, 0, 1, 32, 1, 0);
        tbl[7]  = mk(1, 2, 32, -1, 0, 0,  0, 0, 0);
        tbl[8]  = mk(1, 2, 32, -1, 0, 0,  0, 0, 0);
        tbl[9]  = mk(1, 2, 32, -1, 0, 1, 32, 1, 0);
        tbl[10] = mk(1, 2, 32, -1, 0, 0,  0, 0, 0);
        tbl[11] = mk(1, 0, 32, -1, 0, 0,  0, 0, 0);
        tbl[12] = mk(1, 0, 32, 10, 0, 1, 10, 0, 0);
        tbl[13] = mk(1, 0, 32, -1, 0, 1, 32, 1, 0);
        tbl[14] = mk(1, 0, 24, -1, 0, 1, 24, 1, 1);
        tbl[15] = mk(1, 0, 33, -1, 0, 1, 33, 1, 1);
        tbl[16] = mk(0, 0, 32, -1, 0, 1, 32, 1, 0);
        tbl[17] = mk(1, 0, 32, -1, 1, 0,  0, 0, 0);
        tbl[18] = mk(0, 0, 32, -1, 0, 0,  0, 0, 0);

        rst_n       = 1'b0;
        img_vsync   = 1'b1;
        img_data_en = 1'b0;
        xfer_req    = 1'b0;
        skip_n      = 4'd0;
        fifo_full   = 1'b0;
        repeat (3) tick();
        check("rst_flag", 32'(transfer_flag), 32'd0);
        check("rst_pulses", 32'({frame_done, frame_err, pix_en}), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 19; i++)
            do_frame(tbl[i], 1'b1);

        // Reset in the middle of a sent frame.
        do_frame(mk(1, 0, 32, -1, 0, 0, 0, 0, 0), 1'b0);
        repeat (4) tick();
        img_vsync = 1'b0;
        repeat (3) tick();
        check("rst_mid_pre_flag", 32'(transfer_flag), 32'(m_next));
        img_data_en = 1'b1;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {6'd0, transfer_flag, pix_en, frame_done, frame_err, frame_cnt, drop_cnt}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        p0 = n_pix;
        repeat (8) tick();
        check("rst_mid_no_pix", n_pix - p0, 32'd0);
        check("rst_mid_flag", 32'(transfer_flag), 32'd0);
        img_data_en = 1'b0;
        repeat (2) tick();
        img_vsync = 1'b1;
        repeat (5) tick();
        model_decide();
        do_frame(mk(1, 0, 32, -1, 0, 0, 0, 0, 0), 1'b0);

        // Randomised frames against the model.
        for (int i = 0; i < 40; i++) begin
            f.req = ($urandom_range(0, 9) != 0);
            f.skn = 4'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       f.beats = 24;
                1:       f.beats = 33;
                2:       f.beats = int'($urandom_range(20, 40));
                default: f.beats = 32;
            endcase
            f.ovf      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, f.beats - 1)) : -1;
            f.arm_drop = ($urandom_range(0, 9) == 0);
            f.e_sent = 1'b0; f.e_pix = 0; f.e_done = 0; f.e_err = 0;
            do_frame(f, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
